// File: rtl/pe_column_feeder.sv
// Feeds one three-unit PE column: buffers three filter words and three ifmap rows,
// then streams the rows one pixel per cycle and flags which cycles carry valid psums.
module pe_column_feeder #(
    parameter int unsigned IMG_W  = 8,
    parameter int unsigned PE_LAT = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        wgt_valid,
    output logic        wgt_ready,
    input  logic [11:0] wgt_data,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic [7:0]  pix_data,
    output logic [7:0]  ifmap_out_2,
    output logic [7:0]  ifmap_out_1,
    output logic [7:0]  ifmap_out_0,
    output logic [11:0] filt_out_2,
    output logic [11:0] filt_out_1,
    output logic [11:0] filt_out_0,
    output logic        pe_en,
    output logic        psum_valid,
    output logic        busy,
    output logic        done
);

    localparam int unsigned PIX_N   = 3 * IMG_W;
    localparam int unsigned PIX_CW  = $clog2(PIX_N);
    localparam int unsigned LAT_CW  = $clog2(PE_LAT + 1);
    localparam int unsigned CNT_W   = (PIX_CW > LAT_CW) ? PIX_CW : LAT_CW;
    localparam int unsigned COL_W   = $clog2(IMG_W);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        LOAD_PIX,
        STREAM,
        DRAIN,
        DONE
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_next;
    logic [1:0]         row;
    logic [1:0]         row_next;
    logic [COL_W-1:0]   col;
    logic [COL_W-1:0]   col_next;
    logic [PE_LAT:0]    psum_sr;

    logic               wgt_acc;
    logic               pix_acc;
    logic               stream_next;
    logic [7:0]         ifmap_next_2;
    logic [7:0]         ifmap_next_1;
    logic [7:0]         ifmap_next_0;

    logic [7:0]         row_mem [3][IMG_W];

    assign wgt_acc    = wgt_valid & wgt_ready;
    assign pix_acc    = pix_valid & pix_ready;
    assign psum_valid = psum_sr[PE_LAT];

    // Next-state, counter and next-output decode
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        row_next     = row;
        col_next     = col;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = LOAD_W;
                    cnt_next   = '0;
                end
            end
            LOAD_W: begin
                if (wgt_acc) begin
                    if (cnt == CNT_W'(2)) begin
                        state_next = LOAD_PIX;
                        row_next   = '0;
                        col_next   = '0;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
            end
            LOAD_PIX: begin
                if (pix_acc) begin
                    if (col == COL_W'(IMG_W - 1)) begin
                        col_next = '0;
                        if (row == 2'd2) begin
                            state_next = STREAM;
                        end else begin
                            row_next = row + 2'd1;
                        end
                    end else begin
                        col_next = col + COL_W'(1);
                    end
                end
            end
            STREAM: begin
                if (col == COL_W'(IMG_W - 1)) begin
                    state_next = DRAIN;
                    cnt_next   = '0;
                end else begin
                    col_next = col + COL_W'(1);
                end
            end
            DRAIN: begin
                if (cnt == CNT_W'(PE_LAT - 1)) begin
                    state_next = DONE;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        stream_next  = (state_next == STREAM);
        ifmap_next_2 = stream_next ? row_mem[2][col_next] : 8'h00;
        ifmap_next_1 = stream_next ? row_mem[1][col_next] : 8'h00;
        ifmap_next_0 = stream_next ? row_mem[0][col_next] : 8'h00;
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            row         <= '0;
            col         <= '0;
            psum_sr     <= '0;
            wgt_ready   <= 1'b0;
            pix_ready   <= 1'b0;
            pe_en       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            ifmap_out_2 <= '0;
            ifmap_out_1 <= '0;
            ifmap_out_0 <= '0;
            filt_out_2  <= '0;
            filt_out_1  <= '0;
            filt_out_0  <= '0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            row         <= row_next;
            col         <= col_next;
            psum_sr     <= {psum_sr[PE_LAT-1:0], stream_next};
            wgt_ready   <= (state_next == LOAD_W);
            pix_ready   <= (state_next == LOAD_PIX);
            pe_en       <= (state_next == STREAM) || (state_next == DRAIN);
            busy        <= (state_next != IDLE);
            done        <= (state_next == DONE);
            ifmap_out_2 <= ifmap_next_2;
            ifmap_out_1 <= ifmap_next_1;
            ifmap_out_0 <= ifmap_next_0;
            if (wgt_acc) begin
                if (cnt == CNT_W'(0)) begin
                    filt_out_0 <= wgt_data;
                end else if (cnt == CNT_W'(1)) begin
                    filt_out_1 <= wgt_data;
                end else begin
                    filt_out_2 <= wgt_data;
                end
            end
        end
    end

    // Row buffer: contents are don't-care after reset
    always_ff @(posedge clk) begin
        if (pix_acc) begin
            row_mem[row][col] <= pix_data;
        end
    end

endmodule

// File: tb/tb_pe_column_feeder.sv
// Self-checking bench for pe_column_feeder: reset/handshake vector table plus
// randomized jobs checked cycle by cycle against a timeline model of the job.
module tb_pe_column_feeder;

    localparam int W = 8;
    localparam int L = 3;
    localparam int N = 3 * W;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        wgt_valid;
    logic        wgt_ready;
    logic [11:0] wgt_data;
    logic        pix_valid;
    logic        pix_ready;
    logic [7:0]  pix_data;
    logic [7:0]  ifmap_out_2, ifmap_out_1, ifmap_out_0;
    logic [11:0] filt_out_2, filt_out_1, filt_out_0;
    logic        pe_en, psum_valid, busy, done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0]  pix_mem [N];
    logic [11:0] exp_filt [3];
    logic [65:0] act;

    pe_column_feeder #(.IMG_W(W), .PE_LAT(L)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .wgt_valid(wgt_valid), .wgt_ready(wgt_ready), .wgt_data(wgt_data),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .ifmap_out_2(ifmap_out_2), .ifmap_out_1(ifmap_out_1), .ifmap_out_0(ifmap_out_0),
        .filt_out_2(filt_out_2), .filt_out_1(filt_out_1), .filt_out_0(filt_out_0),
        .pe_en(pe_en), .psum_valid(psum_valid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign act = {wgt_ready, pix_ready, pe_en, psum_valid, busy, done,
                  ifmap_out_2, ifmap_out_1, ifmap_out_0,
                  filt_out_2, filt_out_1, filt_out_0};

    function automatic logic [65:0] pk(input logic wr, pr, pe, pv, bz, dn,
                                       input logic [7:0] i2, i1, i0,
                                       input logic [11:0] f2, f1, f0);
        return {wr, pr, pe, pv, bz, dn, i2, i1, i0, f2, f1, f0};
    endfunction

    task automatic chk(input string nm, input logic [65:0] a, input logic [65:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    task automatic chk_int(input string nm, input int a, input int e);
        checks++;
        if (a != e) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, a, e);
        end
    endtask

    function automatic bit rnd_valid(input int stall);
        return int'($urandom_range(99)) >= stall;
    endfunction

    // One job: drives start/weights/pixels and compares every cycle against the
    // timeline implied by the accept cycles (expected ready is the model's own).
    task automatic run_job(input logic [11:0] w0, w1, w2, input int stall,
                           input bit start_in_stream, input int abort_at, input int id);
        logic [11:0] w [3];
        logic [7:0]  i_e [3];
        int nw, np, t0, ts, tdone, n_pe, n_pv;
        bit wr_e, pr_e, act_s, pe_e, pv_e, dn_e, bz_e, wacc, pacc, finished;
        w[0] = w0; w[1] = w1; w[2] = w2;
        nw = 0; np = 0; ts = -1; tdone = -1; n_pe = 0; n_pv = 0; finished = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; wgt_valid = 1'b0; pix_valid = 1'b0; t0 = cyc;
        for (int k = 0; k < 4000 && !finished; k++) begin
            @(negedge clk);
            wr_e  = (cyc > t0) && (nw < 3);
            pr_e  = (nw == 3) && (np < N);
            act_s = (ts >= 0) && (cyc >= ts) && (cyc < ts + W);
            pe_e  = (ts >= 0) && (cyc >= ts) && (cyc < ts + W + L);
            pv_e  = (ts >= 0) && (cyc >= ts + L) && (cyc < ts + L + W);
            dn_e  = (ts >= 0) && (cyc == ts + W + L);
            bz_e  = (cyc > t0) && !((ts >= 0) && (cyc > ts + W + L));
            for (int r = 0; r < 3; r++)
                i_e[r] = act_s ? pix_mem[r * W + cyc - ts] : 8'h00;
            chk($sformatf("job%0d cycle %0d", id, cyc - t0), act,
                pk(wr_e, pr_e, pe_e, pv_e, bz_e, dn_e, i_e[2], i_e[1], i_e[0],
                   exp_filt[2], exp_filt[1], exp_filt[0]));
            if (pe_en) n_pe++;
            if (psum_valid) n_pv++;
            if (done) tdone = cyc;
            wacc = wgt_valid && wr_e;
            pacc = pix_valid && pr_e;
            if (wacc) begin
                exp_filt[nw] = w[nw];
                nw++;
            end
            if (pacc) begin
                np++;
                if (np == N) ts = cyc + 1;
            end
            if (ts >= 0 && cyc == ts + W + L + 1) finished = 1'b1;
            if (abort_at > 0 && pacc && np == abort_at) begin
                @(posedge clk); #1;
                rst_n = 1'b0; start = 1'b0; wgt_valid = 1'b0; pix_valid = 1'b0;
                #1;
                for (int r = 0; r < 3; r++) exp_filt[r] = 12'h000;
                chk($sformatf("job%0d async reset", id), act, 66'h0);
                @(negedge clk);
                chk($sformatf("job%0d reset held", id), act, 66'h0);
                @(posedge clk); #1;
                rst_n = 1'b1;
                return;
            end
            if (!finished) begin
                @(posedge clk); #1;
                start = start_in_stream && (ts >= 0) && (cyc == ts + 2);
                if (nw < 3) begin
                    wgt_valid = rnd_valid(stall);
                    wgt_data  = w[nw];
                    pix_valid = 1'($urandom_range(1));
                    pix_data  = 8'($urandom);
                end else begin
                    wgt_valid = 1'($urandom_range(1));
                    wgt_data  = 12'($urandom);
                    if (np < N) begin
                        pix_valid = rnd_valid(stall);
                        pix_data  = pix_mem[np];
                    end else begin
                        pix_valid = 1'($urandom_range(1));
                        pix_data  = 8'($urandom);
                    end
                end
            end
        end
        start = 1'b0; wgt_valid = 1'b0; pix_valid = 1'b0;
        if (!finished) begin
            checks++;
            errors++;
            $display("FAIL job%0d timeout: no completion within 4000 cycles", id);
        end else begin
            chk_int($sformatf("job%0d pe_en cycles", id), n_pe, W + L);
            chk_int($sformatf("job%0d psum_valid cycles", id), n_pv, W);
            if (stall == 0)
                chk_int($sformatf("job%0d start-to-done", id), tdone - t0,
                        1 + 3 + 3 * W + W + L);
        end
    endtask

    typedef struct {
        logic        rst_n;
        logic        start;
        logic        wv;
        logic [11:0] wd;
        logic        pv;
        logic [7:0]  pd;
        logic [65:0] exp;
    } vec_t;

    vec_t tbl [10];

    initial begin
        rst_n = 1'b0; start = 1'b0; wgt_valid = 1'b0; wgt_data = '0;
        pix_valid = 1'b0; pix_data = '0;
        for (int r = 0; r < 3; r++) exp_filt[r] = 12'h000;

        tbl[0] = '{1'b0, 1'b1, 1'b1, 12'($urandom), 1'b1, 8'($urandom), 66'h0};
        tbl[1] = '{1'b0, 1'b0, 1'b1, 12'($urandom), 1'b1, 8'($urandom), 66'h0};
        tbl[2] = '{1'b1, 1'b0, 1'b1, 12'($urandom), 1'b1, 8'($urandom), 66'h0};
        tbl[3] = '{1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 8'h00, 66'h0};
        tbl[4] = '{1'b1, 1'b1, 1'b0, 12'h000, 1'b0, 8'h00, 66'h0};
        tbl[5] = '{1'b1, 1'b0, 1'b1, 12'h123, 1'b1, 8'hAA,
                   pk(1, 0, 0, 0, 1, 0, 0, 0, 0, 12'h000, 12'h000, 12'h000)};
        tbl[6] = '{1'b1, 1'b0, 1'b1, 12'h456, 1'b1, 8'hBB,
                   pk(1, 0, 0, 0, 1, 0, 0, 0, 0, 12'h000, 12'h000, 12'h123)};
        tbl[7] = '{1'b1, 1'b0, 1'b1, 12'h789, 1'b1, 8'hCC,
                   pk(1, 0, 0, 0, 1, 0, 0, 0, 0, 12'h000, 12'h456, 12'h123)};
        tbl[8] = '{1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 8'h00,
                   pk(0, 1, 0, 0, 1, 0, 0, 0, 0, 12'h789, 12'h456, 12'h123)};
        tbl[9] = '{1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 8'h00, 66'h0};

        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            rst_n = tbl[i].rst_n; start = tbl[i].start;
            wgt_valid = tbl[i].wv; wgt_data = tbl[i].wd;
            pix_valid = tbl[i].pv; pix_data = tbl[i].pd;
            @(negedge clk);
            chk($sformatf("vec%0d", i), act, tbl[i].exp);
        end
        @(posedge clk); #1;
        rst_n = 1'b1; start = 1'b0; wgt_valid = 1'b0; pix_valid = 1'b0;

        // Nominal job
        for (int i = 0; i < N; i++) pix_mem[i] = 8'(i);
        run_job(12'h123, 12'h456, 12'h789, 0, 1'b0, 0, 1);

        // Backpressure with start pulsed mid-stream
        for (int i = 0; i < N; i++) pix_mem[i] = 8'($urandom);
        run_job(12'($urandom), 12'($urandom), 12'($urandom), 40, 1'b1, 0, 2);

        // Back-to-back job with new weights
        for (int i = 0; i < N; i++) pix_mem[i] = 8'(i);
        run_job(12'hABC, 12'hDEF, 12'h135, 0, 1'b0, 0, 3);

        // Reset after 10 pixels, then a fresh nominal job
        for (int i = 0; i < N; i++) pix_mem[i] = 8'($urandom);
        run_job(12'h9A9, 12'h5C5, 12'h3E3, 20, 1'b0, 10, 4);
        for (int i = 0; i < N; i++) pix_mem[i] = 8'(i);
        run_job(12'h123, 12'h456, 12'h789, 0, 1'b0, 0, 5);

        for (int j = 0; j < 3; j++) begin
            for (int i = 0; i < N; i++) pix_mem[i] = 8'($urandom);
            run_job(12'($urandom), 12'($urandom), 12'($urandom), 30, 1'b0, 0, 6 + j);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
